game_timer: RTL and testbench

Parametrised game countdown timer for the whack-a-mole datapath, clocked by the 1 Hz tick derived from CLOCK_50. It loads a programmable start time, counts down once per second while the game runs, and supports pause/resume, bonus-time insertion with saturation, a low-time warning flag and an expiry indication. Its outputs feed the game FSM (end-of-round) and the 7-segment score/time display.

---
 rtl/game_timer.sv | 143 ++++++++++++++
 tb/tb_game_timer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_timer.sv
// game_timer: whack-a-mole round countdown, one decision per rising clk_1Hz.
// Loads START_VALUE, counts down while running, supports pause/resume,
// saturating bonus insertion, a low-time warning and a one-cycle time_up
// pulse on expiry.
// Optional feature macro: GAME_TIMER_BCD_EN adds bcd_tens/bcd_ones outputs.
// Handshake note: there is no valid/ready traffic here; start_game and pause
// are levels and add_time is sampled on every edge, so each input must be held
// stable across at least one full clk_1Hz period to be seen.
module game_timer #(
    parameter int WIDTH       = 6,
    parameter int START_VALUE = 60,
    parameter int MAX_VALUE   = 60,
    parameter int BONUS       = 5,
    parameter int WARN_THRESH = 10
) (
    input  logic             clk_1Hz,
    input  logic             reset,
    input  logic             start_game,
    input  logic             pause,
    input  logic             add_time,
    output logic [WIDTH-1:0] counter,
    output logic             running,
    output logic             paused,
    output logic             expired,
    output logic             time_up,
    output logic             warning,
    output logic [1:0]       dbg_state_o
`ifdef GAME_TIMER_BCD_EN
    ,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSED  = 2'd2,
        S_EXPIRED = 2'd3
    } state_e;

    localparam logic [WIDTH-1:0] START_W = WIDTH'(START_VALUE);
    localparam logic [WIDTH:0]   MAX_W   = (WIDTH+1)'(MAX_VALUE);
    localparam logic [WIDTH:0]   BONUS_W = (WIDTH+1)'(BONUS);
    localparam logic [WIDTH:0]   WARN_W  = (WIDTH+1)'(WARN_THRESH);
    localparam logic [WIDTH:0]   ONE_W   = (WIDTH+1)'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] counter_q, counter_d;
    logic             time_up_q, time_up_d;
    logic             running_q, paused_q, expired_q;
    logic [WIDTH:0]   sum;   // one extra bit so counter-1+BONUS cannot wrap

    // Next-state and next-counter decision for the coming clk_1Hz edge.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        time_up_d = 1'b0;
        sum       = {1'b0, counter_q} - ONE_W + (add_time ? BONUS_W : '0);
        unique case (state_q)
            S_IDLE: begin
                counter_d = START_W;
                if (start_game) state_d = S_RUN;   // no decrement on start edge
            end
            S_RUN: begin
                if (!start_game) begin
                    state_d   = S_IDLE;
                    counter_d = START_W;
                end else if (pause) begin
                    state_d = S_PAUSED;            // bonus ignored while pausing
                end else begin
                    // A bonus on the last second yields BONUS, so it rescues the round.
                    if (sum > MAX_W) counter_d = MAX_W[WIDTH-1:0];
                    else             counter_d = sum[WIDTH-1:0];
                    if (sum == '0) begin
                        state_d   = S_EXPIRED;
                        time_up_d = 1'b1;
                    end
                end
            end
            S_PAUSED: begin
                if (!start_game) begin
                    state_d   = S_IDLE;
                    counter_d = START_W;
                end else if (!pause) begin
                    state_d = S_RUN;               // no decrement on resume edge
                end
            end
            S_EXPIRED: begin
                counter_d = '0;
                if (!start_game) begin
                    state_d   = S_IDLE;
                    counter_d = START_W;
                end
            end
            default: begin
                state_d   = S_IDLE;
                counter_d = START_W;
            end
        endcase
    end

    // State, counter and status flags, all registered with async active-low reset.
    always_ff @(posedge clk_1Hz or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            counter_q <= START_W;
            time_up_q <= 1'b0;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            time_up_q <= time_up_d;
            running_q <= (state_d == S_RUN);
            paused_q  <= (state_d == S_PAUSED);
            expired_q <= (state_d == S_EXPIRED);
        end
    end

    assign counter     = counter_q;
    assign running     = running_q;
    assign paused      = paused_q;
    assign expired     = expired_q;
    assign time_up     = time_up_q;
    assign dbg_state_o = state_q;

    // Low-time warning only while a round is live (RUN or PAUSED).
    always_comb begin
        warning = ((state_q == S_RUN) || (state_q == S_PAUSED)) &&
                  ({1'b0, counter_q} <= WARN_W);
    end

`ifdef GAME_TIMER_BCD_EN
    // Two-digit decimal split for the display; meaningful up to 99.
    always_comb begin
        bcd_tens = 4'(counter_q / WIDTH'(10));
        bcd_ones = 4'(counter_q % WIDTH'(10));
    end
`endif

endmodule

// File: tb/tb_game_timer.sv
// tb_game_timer: directed scenarios plus randomized play checked against a
// behavioural model of the round rules.
module tb_game_timer;

    localparam int WIDTH       = 6;
    localparam int START_VALUE = 60;
    localparam int MAX_VALUE   = 60;
    localparam int BONUS       = 5;
    localparam int WARN_THRESH = 10;

    // ---------------- clock / reset ----------------
    logic clk_1Hz = 1'b0;
    logic reset   = 1'b0;
    always #5 clk_1Hz = ~clk_1Hz;

    logic             start_game = 1'b0;
    logic             pause      = 1'b0;
    logic             add_time   = 1'b0;
    logic [WIDTH-1:0] counter;
    logic             running, paused, expired, time_up, warning;
    logic [1:0]       dbg_state;
`ifdef GAME_TIMER_BCD_EN
    logic [3:0]       bcd_tens, bcd_ones;
`endif

    game_timer #(
        .WIDTH(WIDTH), .START_VALUE(START_VALUE), .MAX_VALUE(MAX_VALUE),
        .BONUS(BONUS), .WARN_THRESH(WARN_THRESH)
    ) dut (
        .clk_1Hz    (clk_1Hz),
        .reset      (reset),
        .start_game (start_game),
        .pause      (pause),
        .add_time   (add_time),
        .counter    (counter),
        .running    (running),
        .paused     (paused),
        .expired    (expired),
        .time_up    (time_up),
        .warning    (warning),
        .dbg_state_o(dbg_state)
`ifdef GAME_TIMER_BCD_EN
        ,
        .bcd_tens   (bcd_tens),
        .bcd_ones   (bcd_ones)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The round is described by three facts: is a game on, is it frozen,
    // has the time run out; plus the remaining seconds.
    bit m_on, m_frozen, m_over, m_tu;
    int m_secs;

    task automatic model_reset();
        m_on = 0; m_frozen = 0; m_over = 0; m_tu = 0;
        m_secs = START_VALUE;
    endtask

    task automatic model_step();
        int n;
        m_tu = 0;
        if (!m_on && !m_over) begin
            if (start_game) m_on = 1;
            m_secs = START_VALUE;
        end else if (!start_game) begin
            model_reset();                       // abort from any active mode
        end else if (m_over) begin
            m_secs = 0;
        end else if (m_frozen) begin
            if (!pause) m_frozen = 0;
        end else if (pause) begin
            m_frozen = 1;
        end else begin
            n = m_secs - 1 + (add_time ? BONUS : 0);
            if (n > MAX_VALUE) n = MAX_VALUE;
            m_secs = n;
            if (n == 0) begin
                m_on = 0; m_over = 1; m_tu = 1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        exp_q.push_back(32'(m_secs));
        check({tag, ".counter"}, 32'(counter), exp_q.pop_front());
        check({tag, ".running"}, 32'(running), 32'(m_on && !m_frozen));
        check({tag, ".paused"},  32'(paused),  32'(m_on && m_frozen));
        check({tag, ".expired"}, 32'(expired), 32'(m_over));
        check({tag, ".time_up"}, 32'(time_up), 32'(m_tu));
        check({tag, ".warning"}, 32'(warning), 32'(m_on && m_secs <= WARN_THRESH));
`ifdef GAME_TIMER_BCD_EN
        check({tag, ".bcd_tens"}, 32'(bcd_tens), 32'(m_secs / 10));
        check({tag, ".bcd_ones"}, 32'(bcd_ones), 32'(m_secs % 10));
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input string tag);
        @(posedge clk_1Hz);
        #1;
        model_step();
        compare_all(tag);
    endtask

    task automatic run_until(input string tag, input int target);
        int n = 0;
        while (m_secs != target && n < 100) begin
            tick(tag);
            n++;
        end
        check({tag, ".reach"}, 32'(counter), 32'(target));
    endtask

    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        #1;
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        model_reset();
        #12;
        compare_all("reset");
        #1 reset = 1'b1;

        // Full countdown with no pause or bonus.
        start_game = 1'b1;
        n = 0;
        do begin
            tick("count");
            n++;
        end while (!expired && n < 100);
        check("expiry_edges", 32'(n), 32'(START_VALUE + 1));
        tick("exp_hold1");
        tick("exp_hold2");
        pause = 1'b1; add_time = 1'b1;
        tick("exp_ignore");
        pause = 1'b0; add_time = 1'b0;
        start_game = 1'b0;
        tick("abort_expired");

        // Warning and pause/resume at counter 10.
        start_game = 1'b1;
        run_until("to10", 10);
        check("warn_at10", 32'(warning), 32'd1);
        pause = 1'b1;
        add_time = 1'b1;
        for (int i = 0; i < 3; i++) tick("paused");
        add_time = 1'b0;
        pause = 1'b0;
        tick("resume");
        tick("after_resume");
        check("after_resume9", 32'(counter), 32'd9);

        // Abort from PAUSED.
        pause = 1'b1;
        tick("pause_again");
        start_game = 1'b0;
        tick("abort_paused");

        // Bonus clamp at 58 and last-second rescue.
        pause = 1'b0;
        start_game = 1'b1;
        run_until("to58", 58);
        add_time = 1'b1;
        tick("bonus_clamp");
        check("clamp60", 32'(counter), 32'(MAX_VALUE));
        add_time = 1'b0;
        run_until("to1", 1);
        add_time = 1'b1;
        tick("rescue");
        check("rescue5", 32'(counter), 32'(BONUS));
        add_time = 1'b0;

        // Abort from RUN at 33.
        start_game = 1'b0;
        tick("to_idle");
        start_game = 1'b1;
        run_until("to47", 47);
        run_until("to33", 33);
        start_game = 1'b0;
        tick("abort_run");

        // Asynchronous reset mid-second at 20.
        start_game = 1'b1;
        run_until("to20", 20);
        async_reset("async_reset");
        tick("post_reset");

        // Randomized play.
        for (int i = 0; i < 600; i++) begin
            start_game = ($urandom_range(0, 24) != 0);
            pause      = ($urandom_range(0, 5) == 0);
            add_time   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) async_reset("rand_reset");
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
